// File: rtl/fifo_wr_skid_pkg.sv
// Shared types and constants for the fifo_wr_skid write-side front end.
// The state type is shared by the top and any bench that wants to decode
// occupancy.

package fifo_wr_skid_pkg;

    // Skid occupancy. This is decoded from the two valid bits and is never
    // stored on its own.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Step applied to the written-word and stall counters.
    localparam int CNT_INC = 1;

endpackage

// File: rtl/fifo_wr_skid_sat_counter.sv
// sat_counter: saturating up-counter with enable and asynchronous clear.
// It is only used when FIFO_WR_SKID_STATS_EN is defined. Without the macro
// this file compiles to nothing, so no stats logic exists in the default build.

`ifdef FIFO_WR_SKID_STATS_EN
module sat_counter
    import fifo_wr_skid_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles and hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(CNT_INC);
        end
    end

endmodule
`endif

// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: write-side front end for non-FWFT FIFOs.
// A two-entry skid buffer (head + cache) takes a valid/ready producer stream
// and drives a FIFO write port. IN_READY is a register, so WR_FULL never
// reaches the producer combinationally. WR_EN = head valid & !WR_FULL is the
// only combinational path through the block.
// The optional macro FIFO_WR_SKID_STATS_EN adds the STALL_COUNT and
// OVERFLOW_ERR outputs.

module fifo_wr_skid
    import fifo_wr_skid_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [C_WIDTH-1:0]     IN_DATA,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [C_WIDTH-1:0]     WR_DATA,
    output logic                   WR_EN,
    input  logic                   WR_FULL,
    output logic [C_CNT_WIDTH-1:0] WR_COUNT,
    output logic                   IDLE
`ifdef FIFO_WR_SKID_STATS_EN
    ,
    output logic [C_CNT_WIDTH-1:0] STALL_COUNT,
    output logic                   OVERFLOW_ERR
`endif
);

    logic [C_WIDTH-1:0]     head_data;
    logic [C_WIDTH-1:0]     cache_data;
    logic                   head_valid;
    logic                   cache_valid;
    logic                   ready_q;
    logic [C_CNT_WIDTH-1:0] count_q;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   pop;
    logic   load_head_in;
    logic   load_head_cache;
    logic   load_cache_in;

    assign accept = IN_VALID & ready_q;
    assign pop    = head_valid & ~WR_FULL;

    // Decode occupancy from the valid bits. The cache is only ever filled
    // behind a valid head, so a set cache bit always means two words.
    always_comb begin
        state = S_EMPTY;
        if (cache_valid) begin
            state = S_TWO;
        end else if (head_valid) begin
            state = S_ONE;
        end
    end

    // Skid transfer logic: pick the next occupancy and the register loads.
    // The cache is drained into the head before any new word lands in the
    // head, which keeps words in accept order.
    always_comb begin
        state_nxt       = state;
        load_head_in    = 1'b0;
        load_head_cache = 1'b0;
        load_cache_in   = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt    = S_ONE;
                    load_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (pop && accept) begin
                    state_nxt    = S_ONE;
                    load_head_in = 1'b1;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end else if (accept) begin
                    state_nxt     = S_TWO;
                    load_cache_in = 1'b1;
                end
            end
            S_TWO: begin
                // ready_q is low here, so no new word can arrive.
                if (pop) begin
                    state_nxt       = S_ONE;
                    load_head_cache = 1'b1;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // Control registers: valid bits, registered ready and the write counter.
    // An asynchronous reset discards held words immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_valid  <= 1'b0;
            cache_valid <= 1'b0;
            ready_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            head_valid  <= (state_nxt != S_EMPTY);
            cache_valid <= (state_nxt == S_TWO);
            ready_q     <= (state_nxt != S_TWO);
            if (pop) begin
                count_q <= count_q + C_CNT_WIDTH'(CNT_INC);
            end
        end
    end

    // Data registers. They are not reset; the valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (load_head_in) begin
            head_data <= IN_DATA;
        end else if (load_head_cache) begin
            head_data <= cache_data;
        end
        if (load_cache_in) begin
            cache_data <= IN_DATA;
        end
    end

    assign IN_READY = ready_q;
    assign WR_DATA  = head_data;
    assign WR_EN    = pop;
    assign WR_COUNT = count_q;
    assign IDLE     = (state == S_EMPTY);

`ifdef FIFO_WR_SKID_STATS_EN
    logic armed;
    logic overflow_q;

    sat_counter #(
        .WIDTH (C_CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .en    (head_valid & WR_FULL),
        .count (STALL_COUNT)
    );

    // Sticky consistency flag. A stall with an empty cache is impossible
    // once ready has come up. The check is masked for the single cycle after
    // reset, when ready is still low by design.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed && IN_VALID && !ready_q && !cache_valid) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign OVERFLOW_ERR = overflow_q;
`endif

endmodule
